imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, the instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of the first loaded word.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: a byte is offered on rx_data.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the byte stream.
REQ-007 The block SHALL have port restart, input, 1 bit: a reload request, honoured only in DONE or ERROR.
REQ-008 The block SHALL have port rx_ready, output, 1 bit: the block accepts a byte; transfer occurs when rx_valid && rx_ready.
REQ-009 The block SHALL have port imem_we, output, 1 bit: the instruction memory write strobe.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: the word-aligned byte address.
REQ-011 The block SHALL have port imem_wdata, output, 32 bits: the assembled instruction word.
REQ-012 The block SHALL have port core_reset, output, 1 bit: the active-high reset to the processor core.
REQ-013 The block SHALL have port done, output, 1 bit: the image is loaded and accepted.
REQ-014 The block SHALL have port error, output, 1 bit: the load is rejected.

Function
REQ-015 The FSM SHALL have states LEN_LO, LEN_HI, LOAD, CHECK, DONE and ERROR.
REQ-016 In LEN_LO, an accepted byte SHALL be captured as N[7:0], then the FSM SHALL go to LEN_HI.
REQ-017 In LEN_HI, an accepted byte SHALL be captured as N[15:8], and the FSM SHALL move to:
- ERROR if N > DEPTH_WORDS;
- the post-payload state if N == 0;
- LOAD otherwise.
REQ-018 In LOAD, bytes SHALL be assembled little-endian: the first byte of each group of 4 goes to bits [7:0], the fourth to bits [31:24].
REQ-019 On the cycle after the fourth byte of a word is accepted, imem_we SHALL pulse high for exactly 1 cycle, with imem_addr = BASE_ADDR + 4*word_idx and imem_wdata = the assembled word.
REQ-020 word_idx SHALL start at 0 and increment after each write; after the write of word N-1 the FSM SHALL leave LOAD for the post-payload state.
REQ-021 The post-payload state SHALL be CHECK when BOOT_CHECKSUM_EN is defined, and DONE otherwise.
REQ-022 rx_ready SHALL be 1 in LEN_LO, LEN_HI, LOAD and CHECK; it SHALL be 0 in DONE, in ERROR, and in the imem_we cycle.
REQ-023 A cycle with rx_valid=0 SHALL stall the FSM with no state change; there SHALL be no timeout.
REQ-024 core_reset SHALL be 1 in every state except DONE.
REQ-025 In DONE, core_reset SHALL deassert on the same edge on which done asserts.
REQ-026 In ERROR, error SHALL be 1 and core_reset SHALL stay at 1.
REQ-027 restart=1 in DONE or ERROR SHALL clear N, word_idx, the byte count and the checksum, and return the FSM to LEN_LO on the next edge, reasserting core_reset.
REQ-028 restart SHALL be ignored in all other states.
REQ-029 word_idx SHALL be 16 bits wide; imem_addr arithmetic SHALL be modulo 2^32.

Reset
REQ-030 While areset is high, the FSM SHALL be in LEN_LO and all counters and registers SHALL be 0.
REQ-031 While areset is high, the outputs SHALL be: core_reset=1, rx_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, error=0.
REQ-032 areset asserted mid-load SHALL abort the load immediately; words already written SHALL remain in memory and SHALL NOT be rewritten.

Configuration
REQ-033 With BOOT_CHECKSUM_EN defined, the block SHALL keep a running 8-bit XOR of all payload bytes, and CHECK SHALL accept one byte.
REQ-034 In CHECK, if the byte equals the XOR the FSM SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-035 With BOOT_CHECKSUM_EN undefined, the CHECK state and the XOR register SHALL be absent, and the FSM SHALL go from payload straight to DONE.

Structure
REQ-036 A shared package boot_pkg SHALL hold the state enumeration, the CHECKSUM_W=8 constant and the LEN_BYTES=2 constant.
REQ-037 One sub-module, byte_to_word_packer, SHALL hold the byte counter and the 32-bit assembly register and SHALL output word_valid; the FSM SHALL stay in imem_boot_loader.

Verification
REQ-038 Stream 02 00, then 13 00 00 00, then B3 00 00 00 (no checksum) -> writes 0x00000013 at address 0 and 0x000000B3 at address 4, then done=1 and core_reset=0.
REQ-039 Stream 41 00 (N=65, DEPTH_WORDS=64) -> error=1, core_reset=1, imem_we never pulses, rx_ready=0.
REQ-040 Stream 00 00 -> done on the edge after the LEN_HI byte (macro off); with the macro on, checksum byte 00 -> done.
REQ-041 With the macro on, stream 01 00, then 13 00 00 00, then checksum 12 -> error=1; restart, then the same image with checksum 13 -> done=1.
REQ-042 With rx_valid toggled every other cycle during the payload -> the same write sequence and addresses as with a continuous stream.
REQ-043 areset pulsed after 6 payload bytes, then a full valid image -> the load restarts from LEN_LO and words are written from address BASE_ADDR.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CHECK state exists only when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

    localparam int CHECKSUM_W = 8;
    localparam int LEN_BYTES  = 2;
    localparam int LEN_W      = 8 * LEN_BYTES;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        LOAD   = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        CHECK  = 3'd3,
`endif
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    function automatic logic [CHECKSUM_W-1:0] csum_update(
        input logic [CHECKSUM_W-1:0] acc,
        input logic [7:0]            data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four accepted bytes little-endian into a 32-bit word and
// raises word_valid for one cycle after the fourth byte.
module byte_to_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    logic [1:0]  byte_cnt_r;
    logic [31:0] word_r;
    logic        word_valid_r;

    // Byte lane steering, byte counter and the one-cycle word strobe.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            byte_cnt_r   <= 2'd0;
            word_r       <= 32'd0;
            word_valid_r <= 1'b0;
        end else if (clear) begin
            byte_cnt_r   <= 2'd0;
            word_r       <= 32'd0;
            word_valid_r <= 1'b0;
        end else if (byte_valid) begin
            case (byte_cnt_r)
                2'd0:    word_r[7:0]   <= byte_data;
                2'd1:    word_r[15:8]  <= byte_data;
                2'd2:    word_r[23:16] <= byte_data;
                2'd3:    word_r[31:24] <= byte_data;
                default: word_r        <= word_r;
            endcase
            byte_cnt_r   <= byte_cnt_r + 2'd1;
            word_valid_r <= (byte_cnt_r == 2'd3);
        end else begin
            word_valid_r <= 1'b0;
        end
    end

    assign word       = word_r;
    assign word_valid = word_valid_r;
    assign last_byte  = (byte_cnt_r == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: length header, little-endian payload written to
// instruction memory, optional XOR checksum (macro BOOT_CHECKSUM_EN).
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        areset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        restart,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    localparam logic [LEN_W:0] DEPTH_LIM = DEPTH_WORDS[LEN_W:0];
`ifdef BOOT_CHECKSUM_EN
    localparam state_t POST_STATE = CHECK;
`else
    localparam state_t POST_STATE = DONE;
`endif
    localparam logic POST_IS_DONE = (POST_STATE == DONE);

    state_t             state_r;
    logic [LEN_W-1:0]   n_r;
    logic [15:0]        word_idx_r;
    logic [31:0]        addr_r;
    logic               rx_ready_r;
    logic               core_reset_r;
    logic               done_r;
    logic               error_r;
`ifdef BOOT_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] csum_r;
`endif

    logic               accept_s;
    logic               load_byte_s;
    logic               clear_s;
    logic [LEN_W-1:0]   n_full_s;
    logic [31:0]        word_s;
    logic               word_valid_s;
    logic               last_byte_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign load_byte_s = accept_s && (state_r == LOAD);
    assign clear_s     = restart && ((state_r == DONE) || (state_r == ERROR));
    assign n_full_s    = {rx_data, n_r[7:0]};

    byte_to_word_packer u_packer (
        .clk        (CLK),
        .areset     (areset),
        .clear      (clear_s),
        .byte_valid (load_byte_s),
        .byte_data  (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s),
        .last_byte  (last_byte_s)
    );

    // Loader FSM; every status output is registered here.
    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            state_r      <= LEN_LO;
            n_r          <= '0;
            word_idx_r   <= 16'd0;
            addr_r       <= BASE_ADDR;
            rx_ready_r   <= 1'b1;
            core_reset_r <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_r       <= '0;
`endif
        end else begin
            case (state_r)
                LEN_LO: begin
                    if (accept_s) begin
                        n_r[7:0] <= rx_data;
                        state_r  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        n_r[15:8] <= rx_data;
                        if ({1'b0, n_full_s} > DEPTH_LIM) begin
                            state_r    <= ERROR;
                            error_r    <= 1'b1;
                            rx_ready_r <= 1'b0;
                        end else if (n_full_s == '0) begin
                            state_r      <= POST_STATE;
                            rx_ready_r   <= !POST_IS_DONE;
                            done_r       <= POST_IS_DONE;
                            core_reset_r <= !POST_IS_DONE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // The write cycle itself blocks rx_ready, so no byte can land here.
                    if (word_valid_s) begin
                        word_idx_r <= word_idx_r + 16'd1;
                        addr_r     <= addr_r + 32'd4;
                        if (word_idx_r == (n_r - 16'd1)) begin
                            state_r      <= POST_STATE;
                            rx_ready_r   <= !POST_IS_DONE;
                            done_r       <= POST_IS_DONE;
                            core_reset_r <= !POST_IS_DONE;
                        end else begin
                            rx_ready_r <= 1'b1;
                        end
                    end else if (load_byte_s) begin
`ifdef BOOT_CHECKSUM_EN
                        csum_r <= csum_update(csum_r, rx_data);
`endif
                        if (last_byte_s) begin
                            rx_ready_r <= 1'b0;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (accept_s) begin
                        rx_ready_r <= 1'b0;
                        if (rx_data == csum_r) begin
                            state_r      <= DONE;
                            done_r       <= 1'b1;
                            core_reset_r <= 1'b0;
                        end else begin
                            state_r <= ERROR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERROR: begin
                    if (clear_s) begin
                        state_r      <= LEN_LO;
                        n_r          <= '0;
                        word_idx_r   <= 16'd0;
                        addr_r       <= BASE_ADDR;
                        rx_ready_r   <= 1'b1;
                        core_reset_r <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        csum_r       <= '0;
`endif
                    end
                end
                default: begin
                    state_r      <= LEN_LO;
                    rx_ready_r   <= 1'b1;
                    core_reset_r <= 1'b1;
                    done_r       <= 1'b0;
                    error_r      <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = word_valid_s;
    assign imem_addr  = addr_r;
    assign imem_wdata = word_s;
    assign core_reset = core_reset_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Table-driven bench for imem_boot_loader with a write scoreboard; adapts
// to BOOT_CHECKSUM_EN by appending the XOR byte to each accepted image.
module tb_imem_boot_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        areset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        restart;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] seed;
        bit          gap;
        bit          bad_csum;
        bit          poke_restart;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];
    int   n_vecs;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .areset     (areset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .restart    (restart),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (!areset && imem_we === 1'b1) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            check("ready_low_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() > 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("imem_addr", imem_addr, e[63:32]);
                check("imem_wdata", imem_wdata, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.seed ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (rx_ready !== 1'b1 && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        if (gap) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic run_image(input vec_t v, input string tag);
        logic [7:0]  cs;
        logic [31:0] w;
        int          lat;
        int          exp_lat;
        cs = 8'h00;
        send_byte(v.n[7:0], v.gap);
        send_byte(v.n[15:8], v.gap);
        if (v.n <= 16'(DEPTH)) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = word_of(v, i);
                for (int b = 0; b < 4; b++) begin
                    if (b == 3) exp_q.push_back({BASE + 32'(4 * i), w});
                    send_byte(w[8*b +: 8], v.gap);
                    cs = cs ^ w[8*b +: 8];
                    if (v.poke_restart && i == 0 && b == 1) begin
                        restart = 1'b1;
                        @(posedge CLK); #1;
                        restart = 1'b0;
                        check({tag, "_restart_ignored_done"}, 32'(done), 32'd0);
                        check({tag, "_restart_ignored_crst"}, 32'(core_reset), 32'd1);
                    end
                end
            end
            if (CSUM) send_byte(v.bad_csum ? (cs ^ 8'h01) : cs, 1'b0);
        end
        lat = 0;
        while (!(done === 1'b1 || error === 1'b1) && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        exp_lat = (!CSUM && v.n != 16'd0 && v.n <= 16'(DEPTH)) ? 1 : 0;
        if (!v.gap) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done"}, 32'(done), 32'(v.exp_done));
        check({tag, "_error"}, 32'(error), 32'(v.exp_err));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!v.exp_done));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(posedge CLK); #1;
        restart = 1'b0;
        check({tag, "_rs_done"}, 32'(done), 32'd0);
        check({tag, "_rs_error"}, 32'(error), 32'd0);
        check({tag, "_rs_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_rs_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_rs_addr"}, imem_addr, BASE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, imem_addr, BASE);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd2,   32'h0000_0013, 32'h0000_00B3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd65,  32'h0,         32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'd0,   32'h0,         32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'd2,   32'h0000_0013, 32'h0000_00B3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'd64,  32'hDEAD_BEEF, 32'h0102_0304, 32'hA5C3_0F96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0100, 32'h0,        32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'd3,   32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        n_vecs = 7;
`ifdef BOOT_CHECKSUM_EN
        vecs[7] = '{16'd1,   32'h0000_0013, 32'h0,         32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'd1,   32'h0000_0013, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_vecs = 9;
`endif

        areset   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("por");
        areset = 1'b0;
        @(posedge CLK); #1;

        for (int v = 0; v < n_vecs; v++) begin
            run_image(vecs[v], $sformatf("vec%0d", v));
            do_restart($sformatf("vec%0d", v));
        end

        // Abort after six payload bytes: one word written, the partial one dropped.
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_q.push_back({BASE, 32'hCAFE_F00D});
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        areset = 1'b1;
        #1;
        check_reset_outputs("mid_abort");
        @(posedge CLK); #1;
        areset = 1'b0;
        @(posedge CLK); #1;
        check("abort_writes_left", 32'(exp_q.size()), 32'd0);
        run_image(vecs[0], "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
